regfile_sb: RTL
===============

// Module: regfile_sb
// PURPOSE
//  Parametrised multi-read-port register file with a per-register busy scoreboard and a dedicated PC slot.
//  Sits between decode and writeback. Decode reads operands and checks hazards, then claims a destination at issue.
//  Writeback delivers results and releases the claim. The PC slot is refreshed from fetch and read back registered.
// PARAMETERS
//  DATA_W  32              register width in bits
//  ADDR_W  4               address width; depth = 2**ADDR_W
//  NUM_RD  2               number of combinational read ports (1..4)
//  PC_IDX  2**ADDR_W-1     index of the PC slot; not writable through the writeback port
// PORTS
//  clk        in   1                rising-edge clock
//  rst        in   1                asynchronous, active-high reset
//  rd_addr    in   NUM_RD*ADDR_W    read addresses; port i = bits [i*ADDR_W +: ADDR_W]
//  rd_data    out  NUM_RD*DATA_W    read data, combinational
//  rd_busy    out  NUM_RD           1 = addressed register has a pending write
//  rd_pc      out  DATA_W           PC slot, registered copy
//  iss_valid  in   1                issue claims register iss_addr
//  iss_addr   in   ADDR_W           destination register to claim
//  iss_ready  out  1                claim accepted this cycle when iss_valid=1
//  wb_valid   in   1                writeback strobe
//  wb_addr    in   ADDR_W           writeback destination
//  wb_data    in   DATA_W           writeback value
//  pc_en      in   1                load wr_pc into the PC slot
//  wr_pc      in   DATA_W           new PC value
//  pend_cnt   out  ADDR_W+1         number of busy registers
//  err        out  1                sticky protocol-error flag
// BEHAVIOUR
//  - Reset (async, rst=1): all registers 0, busy 0, rd_pc 0, pend_cnt 0, err 0. Reset mid-operation discards all pending claims.
//  - All state updates on posedge clk. The PC slot is excluded from every busy rule below; its busy bit is always 0.
//  - Read port i: rd_data[i] = mem[rd_addr[i]]; rd_busy[i] = busy[rd_addr[i]].
//    A same-cycle writeback is not visible until the next cycle (see CONFIGURATION).
//  - iss_ready = (iss_addr != PC_IDX) && (!busy[iss_addr] || (wb_valid && wb_addr == iss_addr)).
//    An issue is accepted only when iss_valid && iss_ready. An accepted issue sets busy[iss_addr].
//  - A writeback with wb_valid and wb_addr != PC_IDX writes mem[wb_addr] <= wb_data and clears busy[wb_addr].
//  - Writeback and issue in the same cycle to the same address: the data is written and busy ends at 1 (the new claim wins).
//  - A writeback to a non-busy register still writes the data and sets err.
//  - A writeback to PC_IDX is dropped (no write) and sets err.
//  - iss_valid with iss_addr == PC_IDX: not accepted, sets err. iss_valid with iss_ready=0 otherwise is a plain stall: no err, no state change.
//  - PC slot: if pc_en, mem[PC_IDX] <= wr_pc. rd_pc <= mem[PC_IDX] every cycle, so rd_pc lags the slot by one cycle.
//  - pend_cnt is the registered population count of busy. Next value = pend_cnt + accepted issue - valid clearing writeback.
//    A same-address issue+writeback nets 0. Range is 0..2**ADDR_W-1; no wrap is possible.
//  - err is cleared only by rst.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: when wb_valid && wb_addr == rd_addr[i] && wb_addr != PC_IDX:
//    rd_data[i] = wb_data and rd_busy[i] = 0 in the same cycle.
//    Exception: if an issue to that address is also accepted this cycle, rd_busy[i] stays 0 this cycle and the new claim shows from the next cycle.
//  REGFILE_BYPASS_EN undefined: no forwarding. Old data and busy=1 are visible until the cycle after the writeback.
// TESTING
//  1 Reset: rst=1 mid-run with 3 busy regs -> all rd_data 0, pend_cnt 0, err 0, rd_pc 0 asynchronously.
//  2 Issue r3; next cycle rd_addr0=3 -> rd_busy[0]=1, pend_cnt 1.
//    Writeback r3=32'hDEAD_BEEF -> next cycle rd_data[0]=DEADBEEF, rd_busy[0]=0, pend_cnt 0.
//  3 r5 busy; iss_valid r5 without wb -> iss_ready=0, no err.
//    Same cycle wb r5 + iss r5 -> iss_ready=1, data written, busy[5] stays 1, pend_cnt unchanged.
//  4 pc_en, wr_pc=32'h100 -> slot=0x100 after one edge, rd_pc=0x100 after two edges.
//    wb_addr=PC_IDX -> slot unchanged, err=1.
//  5 Bypass: wb r2=32'h1234 with rd_addr1=2 in the same cycle -> rd_data[1]=1234, rd_busy[1]=0 when REGFILE_BYPASS_EN is defined.
//    Without the macro -> old value and busy=1 that cycle.
//  6 Fill: issue every non-PC reg -> pend_cnt=2**ADDR_W-1, all further iss_ready=0.
//    Writeback to a non-busy reg after drain -> err=1.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Decode/writeback/fetch-facing bundle for regfile_sb.
// The master drives addresses, strobes and data; the slave (register file) returns read data and status.
interface regfile_sb_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [DATA_W-1:0]        rd_pc;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     wb_valid;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     pc_en;
  logic [DATA_W-1:0]        wr_pc;
  logic [ADDR_W:0]          pend_cnt;
  logic                     err;

  modport master (
    output rd_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data, pc_en, wr_pc,
    input  rd_data, rd_busy, rd_pc, iss_ready, pend_cnt, err
  );

  modport slave (
    input  rd_addr, iss_valid, iss_addr, wb_valid, wb_addr, wb_data, pc_en, wr_pc,
    output rd_data, rd_busy, rd_pc, iss_ready, pend_cnt, err
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-read-port register file with per-register busy scoreboard and a registered PC slot.
// Define REGFILE_BYPASS_EN to forward same-cycle writebacks onto the read ports.
module regfile_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned PC_IDX = 2**ADDR_W - 1
) (
  input logic         clk,
  input logic         rst,
  regfile_sb_if.slave bus
);
  localparam int unsigned Depth = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(PC_IDX);

  logic [Depth-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [Depth-1:0]             busy_q, busy_d;
  logic [DATA_W-1:0]            rd_pc_q, rd_pc_d;
  logic [ADDR_W:0]              pend_cnt_q, pend_cnt_d;
  logic                         err_q, err_d;

  logic iss_ready, iss_acc, wb_ok, wb_clr;

  always_comb begin
    iss_ready = (bus.iss_addr != PcAddr) &&
                (!busy_q[bus.iss_addr] || (bus.wb_valid && bus.wb_addr == bus.iss_addr));
    iss_acc   = bus.iss_valid && iss_ready;
    wb_ok     = bus.wb_valid && (bus.wb_addr != PcAddr);
    wb_clr    = wb_ok && busy_q[bus.wb_addr];
  end

  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (wb_ok) begin
      mem_d[bus.wb_addr]  = bus.wb_data;
      busy_d[bus.wb_addr] = 1'b0;
    end
    // Issue applied after writeback so a same-address claim wins.
    if (iss_acc) busy_d[bus.iss_addr] = 1'b1;
    if (bus.pc_en) mem_d[PcAddr] = bus.wr_pc;
    rd_pc_d    = mem_q[PcAddr];
    pend_cnt_d = pend_cnt_q + (ADDR_W+1)'(iss_acc) - (ADDR_W+1)'(wb_clr);
    err_d      = err_q
               | (bus.wb_valid && ((bus.wb_addr == PcAddr) || !busy_q[bus.wb_addr]))
               | (bus.iss_valid && (bus.iss_addr == PcAddr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q      <= '0;
      busy_q     <= '0;
      rd_pc_q    <= '0;
      pend_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      busy_q     <= busy_d;
      rd_pc_q    <= rd_pc_d;
      pend_cnt_q <= pend_cnt_d;
      err_q      <= err_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = bus.rd_addr[i*ADDR_W +: ADDR_W];
    always_comb begin
      bus.rd_data[i*DATA_W +: DATA_W] = mem_q[ra];
      bus.rd_busy[i]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      // A same-cycle claim on this address only shows from the next cycle.
      if (wb_ok && (bus.wb_addr == ra)) begin
        bus.rd_data[i*DATA_W +: DATA_W] = bus.wb_data;
        bus.rd_busy[i]                  = 1'b0;
      end
`endif
    end
  end

  assign bus.iss_ready = iss_ready;
  assign bus.rd_pc     = rd_pc_q;
  assign bus.pend_cnt  = pend_cnt_q;
  assign bus.err       = err_q;
endmodule
